// File: rtl/stream_gate_mc_if.sv
// stream_gate_mc_if: bundles the per-channel AXI-Stream lanes and the snooped
// AXI-Lite write channel used by stream_gate_mc.
// master = environment side (sources, adapter, AXI-Lite bus).
// slave  = the gate itself.
interface stream_gate_mc_if #(
  parameter int NUM_CH          = 2,
  parameter int TDATA_NUM_BYTES = 8
);
  logic [NUM_CH*TDATA_NUM_BYTES*8-1:0] in_tdata;
  logic [NUM_CH*TDATA_NUM_BYTES-1:0]   in_tkeep;
  logic [NUM_CH-1:0]                   in_tlast;
  logic [NUM_CH-1:0]                   in_tvalid;
  logic [NUM_CH-1:0]                   in_tready;

  logic [NUM_CH*TDATA_NUM_BYTES*8-1:0] out_tdata;
  logic [NUM_CH*TDATA_NUM_BYTES-1:0]   out_tkeep;
  logic [NUM_CH-1:0]                   out_tlast;
  logic [NUM_CH-1:0]                   out_tvalid;
  logic [NUM_CH-1:0]                   out_tready;

  logic [31:0]                         s_axi_awaddr;
  logic                                s_axi_awvalid;
  logic                                s_axi_awready;
  logic [31:0]                         s_axi_wdata;
  logic                                s_axi_wvalid;
  logic                                s_axi_wready;

  modport master (
    output in_tdata, in_tkeep, in_tlast, in_tvalid, out_tready,
    output s_axi_awaddr, s_axi_awvalid, s_axi_awready,
    output s_axi_wdata, s_axi_wvalid, s_axi_wready,
    input  in_tready, out_tdata, out_tkeep, out_tlast, out_tvalid
  );

  modport slave (
    input  in_tdata, in_tkeep, in_tlast, in_tvalid, out_tready,
    input  s_axi_awaddr, s_axi_awvalid, s_axi_awready,
    input  s_axi_wdata, s_axi_wvalid, s_axi_wready,
    output in_tready, out_tdata, out_tkeep, out_tlast, out_tvalid
  );
endinterface

// File: rtl/stream_gate_mc.sv
// stream_gate_mc: NUM_CH-channel AXI-Stream gate. A channel opens when the
// adapter's command register is written through the snooped AXI-Lite write
// channel and closes itself after a programmed number of tlast-terminated
// packets. The data path is a zero-latency combinational pass-through.
// Optional feature macro: STREAM_GATE_MC_BEAT_LIMIT_EN adds a per-channel
// beat counter that force-closes a window after MAX_BEATS beats and raises a
// sticky overflow flag. Without it, overflow is tied low.
module stream_gate_mc #(
  parameter int          NUM_CH          = 2,
  parameter int          TDATA_NUM_BYTES = 8,
  parameter int          PKT_CNT_W       = 8,
  parameter logic [31:0] CMD_ADDR        = 32'h28,
  parameter logic [31:0] CNT_ADDR        = 32'h2C,
  parameter int          CMD_BIT         = 17,
  parameter int          MAX_BEATS       = 4096
) (
  input  logic              s_axis_aclk,
  input  logic              s_axis_areset,
  stream_gate_mc_if.slave   bus,
  output logic [NUM_CH-1:0] gate_open,
  output logic [NUM_CH-1:0] done,
  output logic [NUM_CH-1:0] overflow
);

  typedef enum logic { IDLE = 1'b0, OPEN = 1'b1 } chState_e;

  chState_e             state_q     [NUM_CH];
  chState_e             state_d     [NUM_CH];
  logic [PKT_CNT_W-1:0] remaining_q [NUM_CH];
  logic [PKT_CNT_W-1:0] remaining_d [NUM_CH];
  logic [PKT_CNT_W-1:0] pktCnt_q;
  logic [PKT_CNT_W-1:0] pktCnt_d;
  logic                 wrFire;
  logic                 cntWrite;
  logic                 cmdWrite;
  logic [NUM_CH-1:0]    armVec;
  logic [NUM_CH-1:0]    handshake;
  logic [NUM_CH-1:0]    finalBeat;
  logic [NUM_CH-1:0]    closePulse;
  logic                 unusedBits;

`ifdef STREAM_GATE_MC_BEAT_LIMIT_EN
  localparam int BEAT_W = $clog2(MAX_BEATS + 1);

  logic [BEAT_W-1:0]    beatCnt_q   [NUM_CH];
  logic [BEAT_W-1:0]    beatCnt_d   [NUM_CH];
  logic [NUM_CH-1:0]    overflow_q;
  logic [NUM_CH-1:0]    overflow_d;
  logic [NUM_CH-1:0]    limitHit;
`endif

  // Decode snooped writes: only an address and data beat accepted in the
  // same cycle count; an all-zero channel mask in an arm command means all.
  always_comb begin
    wrFire   = bus.s_axi_awvalid & bus.s_axi_awready &
               bus.s_axi_wvalid  & bus.s_axi_wready;
    cntWrite = wrFire && (bus.s_axi_awaddr == CNT_ADDR);
    cmdWrite = wrFire && (bus.s_axi_awaddr == CMD_ADDR) && bus.s_axi_wdata[CMD_BIT];
    armVec   = '0;
    if (cmdWrite) begin
      if (bus.s_axi_wdata[NUM_CH-1:0] == '0) begin
        armVec = '1;
      end else begin
        armVec = bus.s_axi_wdata[NUM_CH-1:0];
      end
    end
    pktCnt_d = pktCnt_q;
    if (cntWrite) begin
      if (bus.s_axi_wdata[PKT_CNT_W-1:0] == '0) begin
        pktCnt_d = PKT_CNT_W'(1);
      end else begin
        pktCnt_d = bus.s_axi_wdata[PKT_CNT_W-1:0];
      end
    end
  end

  // Channel state is exposed directly as the gate, so it drops with reset.
  always_comb begin
    for (int c = 0; c < NUM_CH; c++) begin
      gate_open[c] = (state_q[c] == OPEN);
    end
  end

  assign bus.out_tvalid = gate_open & bus.in_tvalid;
  assign bus.in_tready  = gate_open & bus.out_tready;
  assign bus.out_tdata  = bus.in_tdata;
  assign bus.out_tkeep  = bus.in_tkeep;
  assign bus.out_tlast  = bus.in_tlast;
  assign handshake      = bus.out_tvalid & bus.out_tready;

  // Per-channel next state: a final beat closes the window unless an arm in
  // the same cycle reloads it; other arms while open are ignored.
  always_comb begin
    for (int c = 0; c < NUM_CH; c++) begin
      state_d[c]     = state_q[c];
      remaining_d[c] = remaining_q[c];
      closePulse[c]  = 1'b0;
      finalBeat[c]   = handshake[c] && bus.in_tlast[c] &&
                       (remaining_q[c] == PKT_CNT_W'(1));
`ifdef STREAM_GATE_MC_BEAT_LIMIT_EN
      beatCnt_d[c]   = beatCnt_q[c];
      overflow_d[c]  = overflow_q[c];
      limitHit[c]    = handshake[c] && !finalBeat[c] &&
                       (beatCnt_q[c] == BEAT_W'(MAX_BEATS - 1));
`endif
      case (state_q[c])
        IDLE: begin
          if (armVec[c]) begin
            state_d[c]     = OPEN;
            remaining_d[c] = pktCnt_q;
`ifdef STREAM_GATE_MC_BEAT_LIMIT_EN
            beatCnt_d[c]   = '0;
            overflow_d[c]  = 1'b0;
`endif
          end
        end
        OPEN: begin
          if (finalBeat[c]) begin
            closePulse[c] = 1'b1;
            if (armVec[c]) begin
              remaining_d[c] = pktCnt_q;
`ifdef STREAM_GATE_MC_BEAT_LIMIT_EN
              beatCnt_d[c]   = '0;
              overflow_d[c]  = 1'b0;
`endif
            end else begin
              state_d[c]     = IDLE;
              remaining_d[c] = '0;
            end
          end
`ifdef STREAM_GATE_MC_BEAT_LIMIT_EN
          else if (limitHit[c]) begin
            state_d[c]     = IDLE;
            remaining_d[c] = '0;
            closePulse[c]  = 1'b1;
            overflow_d[c]  = 1'b1;
            beatCnt_d[c]   = beatCnt_q[c] + BEAT_W'(1);
          end
`endif
          else begin
            if (handshake[c] && bus.in_tlast[c]) begin
              remaining_d[c] = remaining_q[c] - PKT_CNT_W'(1);
            end
`ifdef STREAM_GATE_MC_BEAT_LIMIT_EN
            if (handshake[c]) begin
              beatCnt_d[c] = beatCnt_q[c] + BEAT_W'(1);
            end
`endif
          end
        end
        default: begin
          state_d[c] = IDLE;
        end
      endcase
    end
  end

  // State, packet-count and shared count-register flops.
  always_ff @(posedge s_axis_aclk or posedge s_axis_areset) begin
    if (s_axis_areset) begin
      pktCnt_q <= PKT_CNT_W'(1);
      for (int c = 0; c < NUM_CH; c++) begin
        state_q[c]     <= IDLE;
        remaining_q[c] <= '0;
      end
    end else begin
      pktCnt_q <= pktCnt_d;
      for (int c = 0; c < NUM_CH; c++) begin
        state_q[c]     <= state_d[c];
        remaining_q[c] <= remaining_d[c];
      end
    end
  end

`ifdef STREAM_GATE_MC_BEAT_LIMIT_EN
  // Beat counters and sticky overflow flags for the beat-limit window.
  always_ff @(posedge s_axis_aclk or posedge s_axis_areset) begin
    if (s_axis_areset) begin
      overflow_q <= '0;
      for (int c = 0; c < NUM_CH; c++) begin
        beatCnt_q[c] <= '0;
      end
    end else begin
      overflow_q <= overflow_d;
      for (int c = 0; c < NUM_CH; c++) begin
        beatCnt_q[c] <= beatCnt_d[c];
      end
    end
  end

  assign overflow = overflow_q;
`else
  assign overflow = '0;
`endif

  assign done       = closePulse;
  assign unusedBits = ^{bus.s_axi_wdata, MAX_BEATS};

endmodule

// File: tb/tb_stream_gate_mc.sv
// tb_stream_gate_mc: directed test-plan sequences followed by randomized
// stimulus, all checked every cycle against a packet-level reference model.
module tb_stream_gate_mc;

  localparam int          NUM_CH    = 2;
  localparam int          TDB       = 8;
  localparam int          PKT_CNT_W = 8;
  localparam int          MAX_BEATS = 16;
  localparam logic [31:0] CMD_ADDR  = 32'h28;
  localparam logic [31:0] CNT_ADDR  = 32'h2C;
  localparam logic [31:0] BAD_ADDR  = 32'h24;
  localparam logic [3:0]  WR        = 4'hF;
  localparam logic [3:0]  NOWR      = 4'h0;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [NUM_CH-1:0] gate_open;
  logic [NUM_CH-1:0] done;
  logic [NUM_CH-1:0] overflow;

  stream_gate_mc_if #(.NUM_CH(NUM_CH), .TDATA_NUM_BYTES(TDB)) bus ();

  stream_gate_mc #(
    .NUM_CH(NUM_CH), .TDATA_NUM_BYTES(TDB), .PKT_CNT_W(PKT_CNT_W),
    .CMD_ADDR(CMD_ADDR), .CNT_ADDR(CNT_ADDR), .CMD_BIT(17), .MAX_BEATS(MAX_BEATS)
  ) dut (
    .s_axis_aclk(clk),
    .s_axis_areset(rst),
    .bus(bus),
    .gate_open(gate_open),
    .done(done),
    .overflow(overflow)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  int ch0Beats = 0;

  // Reference model: per channel, whether the window is open, packets left,
  // beats seen in this window and the sticky overflow flag.
  bit mOpen [NUM_CH];
  int mLeft [NUM_CH];
  int mBeats[NUM_CH];
  bit mOvf  [NUM_CH];
  int mPktCnt;

  logic [NUM_CH*TDB*8-1:0] curData;
  logic [NUM_CH*TDB-1:0]   curKeep;
  logic [NUM_CH-1:0]       curLast, curValid, curReady;

  // Count one comparison and report it if it does not match.
  task automatic checkOutput(input string tag, input logic [127:0] got, input logic [127:0] want);
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, got, want);
    end
  endtask

  task automatic resetModel();
    for (int c = 0; c < NUM_CH; c++) begin
      mOpen[c] = 1'b0; mLeft[c] = 0; mBeats[c] = 0; mOvf[c] = 1'b0;
    end
    mPktCnt = 1;
  endtask

  // Check the DUT at the falling edge, then advance the model over the next rising edge.
  task automatic runCycle();
    logic [NUM_CH-1:0] expOpen, expDone, expOvf, arm;
    bit wr;
    int wv;
    @(negedge clk);
    wr  = bus.s_axi_awvalid && bus.s_axi_awready && bus.s_axi_wvalid && bus.s_axi_wready;
    arm = '0;
    if (!rst && wr && bus.s_axi_awaddr == CMD_ADDR && bus.s_axi_wdata[17]) begin
      arm = bus.s_axi_wdata[NUM_CH-1:0];
      if (arm == '0) arm = {NUM_CH{1'b1}};
    end
    for (int c = 0; c < NUM_CH; c++) begin
      expOpen[c] = mOpen[c];
      expOvf[c]  = mOvf[c];
      expDone[c] = 1'b0;
    end
    for (int c = 0; c < NUM_CH; c++) begin
      bit hs, last;
      hs   = mOpen[c] && curValid[c] && curReady[c];
      last = hs && curLast[c];
      if (!mOpen[c]) begin
        if (arm[c]) begin
          mOpen[c] = 1'b1; mLeft[c] = mPktCnt; mBeats[c] = 0; mOvf[c] = 1'b0;
        end
      end else if (last && mLeft[c] == 1) begin
        expDone[c] = 1'b1;
        if (arm[c]) begin
          mLeft[c] = mPktCnt; mBeats[c] = 0; mOvf[c] = 1'b0;
        end else begin
          mOpen[c] = 1'b0;
        end
      end else if (hs) begin
        mBeats[c]++;
        if (last) mLeft[c]--;
`ifdef STREAM_GATE_MC_BEAT_LIMIT_EN
        if (mBeats[c] == MAX_BEATS) begin
          mOpen[c] = 1'b0; mOvf[c] = 1'b1; expDone[c] = 1'b1;
        end
`endif
      end
    end
    if (!rst && wr && bus.s_axi_awaddr == CNT_ADDR) begin
      wv = int'(bus.s_axi_wdata[PKT_CNT_W-1:0]);
      mPktCnt = (wv == 0) ? 1 : wv;
    end
    checkOutput("gate_open", gate_open, expOpen);
    checkOutput("done", done, expDone);
    checkOutput("overflow", overflow, expOvf);
    checkOutput("out_tvalid", bus.out_tvalid, expOpen & curValid);
    checkOutput("in_tready", bus.in_tready, expOpen & curReady);
    checkOutput("out_tdata", bus.out_tdata, curData);
    checkOutput("out_tkeep", bus.out_tkeep, curKeep);
    checkOutput("out_tlast", bus.out_tlast, curLast);
    if (bus.out_tvalid[0] && bus.out_tready[0]) ch0Beats++;
    @(posedge clk);
    #1;
  endtask

  // Drive one cycle of stream and AXI-Lite inputs, then run it.
  task automatic applyStimulus(input logic [NUM_CH-1:0] v, input logic [NUM_CH-1:0] l,
                               input logic [NUM_CH-1:0] r, input logic [3:0] axiHs,
                               input logic [31:0] addr, input logic [31:0] data);
    curData  = {$urandom, $urandom, $urandom, $urandom};
    curKeep  = 16'($urandom);
    curLast  = l;
    curValid = v;
    curReady = r;
    bus.in_tdata   = curData;
    bus.in_tkeep   = curKeep;
    bus.in_tlast   = l;
    bus.in_tvalid  = v;
    bus.out_tready = r;
    {bus.s_axi_awvalid, bus.s_axi_awready, bus.s_axi_wvalid, bus.s_axi_wready} = axiHs;
    bus.s_axi_awaddr = addr;
    bus.s_axi_wdata  = data;
    runCycle();
  endtask

  task automatic writeReg(input logic [31:0] addr, input logic [31:0] data);
    applyStimulus(2'b00, 2'b00, 2'b11, WR, addr, data);
  endtask

  initial begin
    resetModel();
    $display("[TB] reset state");
    applyStimulus(2'b11, 2'b11, 2'b11, NOWR, 32'h0, 32'h0);
    applyStimulus(2'b11, 2'b00, 2'b11, WR, CMD_ADDR, 32'h0002_0000);
    rst = 1'b0;

    $display("[TB] three 4-beat packets on ch0");
    writeReg(CNT_ADDR, 32'h3);
    writeReg(CMD_ADDR, 32'h0002_0001);
    ch0Beats = 0;
    for (int b = 1; b <= 14; b++) begin
      applyStimulus(2'b11, (b % 4 == 0) ? 2'b11 : 2'b00, 2'b11, NOWR, 32'h0, 32'h0);
    end
    checkOutput("t1_ch0Beats", ch0Beats, 12);
    checkOutput("t1_closed", gate_open, 2'b00);

    $display("[TB] arm all, tlast without valid, ch1 back-pressured");
    writeReg(CNT_ADDR, 32'h1);
    writeReg(CMD_ADDR, 32'h0002_0000);
    for (int i = 0; i < 5; i++) applyStimulus(2'b00, 2'b11, 2'b11, NOWR, 32'h0, 32'h0);
    checkOutput("t3_stillOpen", gate_open, 2'b11);
    applyStimulus(2'b11, 2'b00, 2'b01, NOWR, 32'h0, 32'h0);
    applyStimulus(2'b11, 2'b11, 2'b01, NOWR, 32'h0, 32'h0);
    applyStimulus(2'b11, 2'b11, 2'b01, NOWR, 32'h0, 32'h0);
    checkOutput("t2_ch1Open", gate_open, 2'b10);
    applyStimulus(2'b10, 2'b10, 2'b10, NOWR, 32'h0, 32'h0);
    checkOutput("t2_allClosed", gate_open, 2'b00);

    $display("[TB] re-arm on final beat");
    writeReg(CNT_ADDR, 32'h2);
    writeReg(CMD_ADDR, 32'h0002_0001);
    applyStimulus(2'b01, 2'b00, 2'b11, NOWR, 32'h0, 32'h0);
    applyStimulus(2'b01, 2'b01, 2'b11, NOWR, 32'h0, 32'h0);
    applyStimulus(2'b01, 2'b00, 2'b11, NOWR, 32'h0, 32'h0);
    applyStimulus(2'b01, 2'b01, 2'b11, WR, CMD_ADDR, 32'h0002_0001);
    checkOutput("t4_stillOpen", gate_open[0], 1'b1);
    applyStimulus(2'b01, 2'b01, 2'b11, NOWR, 32'h0, 32'h0);
    checkOutput("t4_reloaded", gate_open[0], 1'b1);
    applyStimulus(2'b01, 2'b01, 2'b11, NOWR, 32'h0, 32'h0);
    checkOutput("t4_closed", gate_open[0], 1'b0);

    $display("[TB] ignored writes and zero packet count");
    writeReg(CMD_ADDR, 32'h0000_0003);
    writeReg(BAD_ADDR, 32'h0002_0003);
    applyStimulus(2'b00, 2'b00, 2'b11, 4'b1110, CMD_ADDR, 32'h0002_0003);
    applyStimulus(2'b00, 2'b00, 2'b11, 4'b0111, CMD_ADDR, 32'h0002_0003);
    checkOutput("t5_noOpen", gate_open, 2'b00);
    writeReg(CNT_ADDR, 32'h0);
    writeReg(CMD_ADDR, 32'h0002_0002);
    applyStimulus(2'b10, 2'b10, 2'b11, NOWR, 32'h0, 32'h0);
    checkOutput("t5_onePacket", gate_open, 2'b00);

    $display("[TB] reset mid-packet");
    writeReg(CNT_ADDR, 32'h4);
    writeReg(CMD_ADDR, 32'h0002_0000);
    applyStimulus(2'b11, 2'b00, 2'b11, NOWR, 32'h0, 32'h0);
    #2 rst = 1'b1;
    #1;
    checkOutput("rstAsync_gate", gate_open, 2'b00);
    checkOutput("rstAsync_valid", bus.out_tvalid, 2'b00);
    checkOutput("rstAsync_done", done, 2'b00);
    resetModel();
    applyStimulus(2'b11, 2'b11, 2'b11, NOWR, 32'h0, 32'h0);
    rst = 1'b0;

`ifdef STREAM_GATE_MC_BEAT_LIMIT_EN
    $display("[TB] beat limit");
    writeReg(CNT_ADDR, 32'h1);
    writeReg(CMD_ADDR, 32'h0002_0001);
    ch0Beats = 0;
    for (int b = 0; b < 20; b++) applyStimulus(2'b01, 2'b00, 2'b11, NOWR, 32'h0, 32'h0);
    checkOutput("t6_beats", ch0Beats, MAX_BEATS);
    checkOutput("t6_ovf", overflow[0], 1'b1);
    writeReg(CMD_ADDR, 32'h0002_0001);
    checkOutput("t6_ovfClear", overflow[0], 1'b0);
    applyStimulus(2'b01, 2'b01, 2'b11, NOWR, 32'h0, 32'h0);
`endif

    $display("[TB] randomized traffic");
    for (int i = 0; i < 400; i++) begin
      logic [3:0]  hsBits;
      logic [31:0] a, d;
      int          pick;
      hsBits = NOWR;
      if ($urandom_range(0, 7) == 0) hsBits = ($urandom_range(0, 3) == 0) ? 4'($urandom) : WR;
      pick = $urandom_range(0, 2);
      a = (pick == 0) ? CMD_ADDR : (pick == 1) ? CNT_ADDR : BAD_ADDR;
      d = $urandom;
      if (pick == 1) d[PKT_CNT_W-1:0] = 8'($urandom_range(0, 3));
      else d[17] = ($urandom_range(0, 3) != 0);
      applyStimulus(2'($urandom), 2'($urandom) & 2'($urandom),
                    2'($urandom) | 2'($urandom), hsBits, a, d);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
